// File: rtl/button_event_pkg.sv
// ---------------------------------------------------------------------------
// button_event_pkg : state encoding and default timing for button_event
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  localparam int DEF_HOLD_CYCLES   = 100_000_000;
  localparam int DEF_REPEAT_CYCLES = 25_000_000;
  localparam int DEF_CNT_W         = 32;

endpackage

`default_nettype wire

// File: rtl/button_event_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for one asynchronous level input
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event : debounced level -> press/release/short/long/repeat pulses
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_event
  import button_event_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic pressed,
  output logic long_held
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_REPEAT_LAST =
    CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam bit               C_REPEAT_EN   = (REPEAT_CYCLES != 0);

  logic             btn_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;
  logic             short_q;
  logic             long_q;
  logic             repeat_q;
  logic             pressed_q;
  logic             long_held_q;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_level),
    .q_o   (btn_s)
  );

  // Release is tested first in every state so it always wins over long/repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      pressed_q   <= 1'b0;
      long_held_q <= 1'b0;
    end else begin
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      pressed_q   <= (state_q != ST_IDLE);
      long_held_q <= (state_q == ST_LONG);
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (btn_s) begin
            state_q <= ST_PRESSED;
            press_q <= 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!btn_s) begin
            state_q   <= ST_IDLE;
            release_q <= 1'b1;
            short_q   <= 1'b1;
            cnt_q     <= '0;
          end else if (cnt_q == C_HOLD_LAST) begin
            state_q <= ST_LONG;
            long_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_LONG: begin
          if (!btn_s) begin
            state_q   <= ST_IDLE;
            release_q <= 1'b1;
            cnt_q     <= '0;
          end else if (C_REPEAT_EN && (cnt_q == C_REPEAT_LAST)) begin
            repeat_q <= 1'b1;
            cnt_q    <= '0;
          end else if (C_REPEAT_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign pressed       = pressed_q;
  assign long_held     = long_held_q;

endmodule

`default_nettype wire

// File: tb/tb_button_event.sv
// ---------------------------------------------------------------------------
// tb_button_event : scoreboard bench, instance A (hold 10, repeat 4) and B (hold 10, repeat 0)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_event;

  localparam int HOLD = 10;
  localparam int REP  = 4;

  localparam logic [4:0] EV_PRESS     = 5'b10000;
  localparam logic [4:0] EV_REL_SHORT = 5'b01100;
  localparam logic [4:0] EV_REL       = 5'b01000;
  localparam logic [4:0] EV_LONG      = 5'b00010;
  localparam logic [4:0] EV_REP       = 5'b00001;

  typedef struct {
    int         inst;
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic btn_a = 1'b0, btn_b = 1'b0;
  logic pr_a, rl_a, sh_a, lg_a, rp_a, pd_a, lh_a;
  logic pr_b, rl_b, sh_b, lg_b, rp_b, pd_b, lh_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  button_event #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_a), .btn_level(btn_a),
    .press_pulse(pr_a), .release_pulse(rl_a), .short_pulse(sh_a),
    .long_pulse(lg_a), .repeat_pulse(rp_a), .pressed(pd_a), .long_held(lh_a)
  );

  button_event #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_b), .btn_level(btn_b),
    .press_pulse(pr_b), .release_pulse(rl_b), .short_pulse(sh_b),
    .long_pulse(lg_b), .repeat_pulse(rp_b), .pressed(pd_b), .long_held(lh_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wire [4:0] ev_a   = {pr_a, rl_a, sh_a, lg_a, rp_a};
  wire [4:0] ev_b   = {pr_b, rl_b, sh_b, lg_b, rp_b};
  wire [6:0] outs_a = {ev_a, pd_a, lh_a};
  wire [6:0] outs_b = {ev_b, pd_b, lh_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int inst, input int c, input logic [4:0] ev);
    exp_t e;
    e.inst = inst;
    e.cyc  = c;
    e.ev   = ev;
    sb.push_back(e);
  endtask

  // Reference event timeline for one press of dur cycles starting at t0.
  task automatic push_model(input int inst, input int t0, input int dur, input int r);
    push(inst, t0, EV_PRESS);
    if (dur > HOLD) begin
      push(inst, t0 + HOLD, EV_LONG);
      if (r > 0)
        for (int t = t0 + HOLD + r; t < t0 + dur; t += r)
          push(inst, t, EV_REP);
    end
    push(inst, t0 + dur, (dur <= HOLD) ? EV_REL_SHORT : EV_REL);
  endtask

  task automatic mon(input int inst, input logic [4:0] ev);
    int idx;
    idx = -1;
    if (ev != 5'b0) begin
      foreach (sb[k])
        if (idx < 0 && sb[k].inst == inst) idx = k;
      if (idx < 0) begin
        check($sformatf("unexpected_ev_%0d", inst), {27'b0, ev}, 32'd0);
      end else begin
        check($sformatf("ev_kind_%0d", inst), {27'b0, ev}, {27'b0, sb[idx].ev});
        check($sformatf("ev_cycle_%0d", inst), cyc, sb[idx].cyc);
        sb.delete(idx);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, ev_a);
    mon(1, ev_b);
  end

  task automatic sb_empty(input int inst);
    int left;
    left = 0;
    foreach (sb[k])
      if (sb[k].inst == inst) left++;
    check($sformatf("sb_empty_%0d", inst), left, 0);
  endtask

  task automatic hold_btn(input int inst, input int dur, input int r);
    int n;
    @(negedge clk);
    n = cyc;
    push_model(inst, n + 3, dur, r);
    if (inst == 0) btn_a = 1'b1; else btn_b = 1'b1;
    for (int k = 1; k <= dur; k++) begin
      @(negedge clk);
      check("pressed_lvl", (inst == 0) ? pd_a : pd_b, (k >= 4) ? 1 : 0);
      if (dur > HOLD && k >= HOLD + 4)
        check("long_held_lvl", (inst == 0) ? lh_a : lh_b, 1);
    end
    if (inst == 0) btn_a = 1'b0; else btn_b = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_pressed", (inst == 0) ? pd_a : pd_b, 0);
    sb_empty(inst);
  endtask

  initial begin
    int n;
    int m;

    // Reset held with button pressed: everything stays quiet.
    btn_a = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs_a", outs_a, 0);
    check("rst_outs_b", outs_b, 0);
    n = cyc;
    push_model(0, n + 3, 6, REP);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (6) @(negedge clk);
    btn_a = 1'b0;
    repeat (8) @(negedge clk);
    sb_empty(0);

    hold_btn(0, 5, REP);
    hold_btn(0, 25, REP);
    hold_btn(0, HOLD, REP);
    hold_btn(1, 40, 0);

    // Reset in the middle of a long hold.
    @(negedge clk);
    n = cyc;
    push(0, n + 3, EV_PRESS);
    push(0, n + 3 + HOLD, EV_LONG);
    push(0, n + 3 + HOLD + REP, EV_REP);
    btn_a = 1'b1;
    repeat (18) @(negedge clk);
    check("long_held_before_rst", lh_a, 1);
    rst_a = 1'b0;
    #1;
    check("rst_async_outs", outs_a, 0);
    repeat (2) @(negedge clk);
    check("rst_hold_outs", outs_a, 0);
    m = cyc;
    push_model(0, m + 3, 12, REP);
    rst_a = 1'b1;
    repeat (12) @(negedge clk);
    btn_a = 1'b0;
    repeat (8) @(negedge clk);
    sb_empty(0);
    sb_empty(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
